// File: rtl/rns_forward_converter_9_8_7_seq_if.sv
// Handshake bundle between a binary producer and the 9/8/7 forward converter.
// Input side: bin_in/in_valid/in_ready. Output side: residues, range_err, out_valid/out_ready.
// master = producer/consumer side, slave = converter side.
interface rns_forward_converter_9_8_7_seq_if #(
    parameter int IN_WIDTH = 9
);
    logic [IN_WIDTH-1:0] bin_in;
    logic                in_valid;
    logic                in_ready;
    logic [3:0]          a1_out;
    logic [2:0]          a2_out;
    logic [2:0]          a3_out;
    logic                range_err;
    logic                out_valid;
    logic                out_ready;

    modport master (
        output bin_in, in_valid, out_ready,
        input  in_ready, a1_out, a2_out, a3_out, range_err, out_valid
    );

    modport slave (
        input  bin_in, in_valid, out_ready,
        output in_ready, a1_out, a2_out, a3_out, range_err, out_valid
    );
endinterface

// File: rtl/rns_forward_converter_9_8_7_seq.sv
// Bit-serial binary -> RNS {9,8,7} converter, MSB first, one operand in flight.
// Latency: accept at edge E0 gives out_valid after edge E0+IN_WIDTH; issue interval IN_WIDTH+2.
// Backpressure: residues held in DONE until out_ready; in_ready only in IDLE.
module rns_forward_converter_9_8_7_seq #(
    parameter int IN_WIDTH = 9,
    parameter int M1       = 9,
    parameter int M2       = 8,
    parameter int M3       = 7,
    parameter int RANGE    = 504
) (
    input  logic clk,
    input  logic rst,
    rns_forward_converter_9_8_7_seq_if.slave bus
);
    localparam int CW = $clog2(IN_WIDTH + 1);
    localparam logic [IN_WIDTH-1:0] RANGE_V = IN_WIDTH'(RANGE);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [IN_WIDTH-1:0] sreg_q;
    logic [CW-1:0]       cnt_q;
    logic [3:0]          r1_q, r1_d;
    logic [2:0]          r2_q, r2_d;
    logic [2:0]          r3_q, r3_d;
    logic [3:0]          a1_q;
    logic [2:0]          a2_q, a3_q;
    logic                err_q;

    logic                b;
    logic [4:0]          t1;
    logic [3:0]          t2, t3;
    logic                last_shift;

    assign b          = sreg_q[IN_WIDTH-1];
    assign last_shift = (cnt_q == CW'(1));

    // Horner step per modulus: t = 2r + b is just {r, b}; t < 2m so one subtract suffices
    always_comb begin
        t1   = {r1_q, b};
        t2   = {r2_q, b};
        t3   = {r3_q, b};
        r1_d = (t1 >= 5'(M1)) ? 4'(t1 - 5'(M1)) : t1[3:0];
        r2_d = (t2 >= 4'(M2)) ? 3'(t2 - 4'(M2)) : t2[2:0];
        r3_d = (t3 >= 4'(M3)) ? 3'(t3 - 4'(M3)) : t3[2:0];
    end

    // Next-state: accept in IDLE, count shifts, wait for downstream in DONE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid) state_d = SHIFT;
            SHIFT:   if (last_shift) state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register; reset aborts any operand in flight
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Datapath: load on accept, shift/accumulate in SHIFT, publish residues on the last shift
    always_ff @(posedge clk) begin
        if (rst) begin
            sreg_q <= '0;
            cnt_q  <= '0;
            r1_q   <= '0;
            r2_q   <= '0;
            r3_q   <= '0;
            a1_q   <= '0;
            a2_q   <= '0;
            a3_q   <= '0;
            err_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        sreg_q <= bus.bin_in;
                        cnt_q  <= CW'(IN_WIDTH);
                        r1_q   <= '0;
                        r2_q   <= '0;
                        r3_q   <= '0;
                        err_q  <= (bus.bin_in >= RANGE_V);
                    end
                end
                SHIFT: begin
                    sreg_q <= {sreg_q[IN_WIDTH-2:0], 1'b0};
                    cnt_q  <= cnt_q - CW'(1);
                    r1_q   <= r1_d;
                    r2_q   <= r2_d;
                    r3_q   <= r3_d;
                    if (last_shift) begin
                        a1_q <= r1_d;
                        a2_q <= r2_d;
                        a3_q <= r3_d;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE) && !rst;
    assign bus.out_valid = (state_q == DONE);
    assign bus.a1_out    = a1_q;
    assign bus.a2_out    = a2_q;
    assign bus.a3_out    = a3_q;
    assign bus.range_err = err_q;
endmodule

// File: tb/tb_rns_forward_converter_9_8_7_seq.sv
// Scoreboard bench: driver pushes expected residues (plain % arithmetic) on accept,
// monitor pops and compares on every output handshake and checks handshake timing.
module tb_rns_forward_converter_9_8_7_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    rns_forward_converter_9_8_7_seq_if #(.IN_WIDTH(9)) bus();

    rns_forward_converter_9_8_7_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int v;
        int e1;
        int e2;
        int e3;
        int err;
        int acc;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   rdy_mode = 0;     // 0: always ready, 1: random, 2: manual
    logic man_rdy = 1'b0;
    logic done = 1'b0;

    function automatic void chk(string nm, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    function automatic int sgn10(int x);
        return (x < 10) ? -1 : ((x == 10) ? 0 : 1);
    endfunction

    // downstream ready generator
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = 1'($urandom_range(0, 1));
                default: bus.out_ready = man_rdy;
            endcase
        end
    end

    // monitor / scoreboard
    initial begin
        logic rst_prev = 1'b0;
        logic busy = 1'b0;
        logic post_hs = 1'b0;
        logic prev_ov = 1'b0;
        int   busy_cnt = 0;
        int   stall_cnt = 0;
        forever begin
            @(negedge clk);
            if (done) begin
                chk("drain", q.size(), 0);
                $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
                $finish;
            end
            if (rst) begin
                if (rst_prev) begin
                    chk("rst_in_ready", int'(bus.in_ready), 0);
                    chk("rst_out_valid", int'(bus.out_valid), 0);
                end
                q.delete();
                busy = 1'b0;
                post_hs = 1'b0;
                prev_ov = 1'b0;
                busy_cnt = 0;
                stall_cnt = 0;
            end else begin
                if (rst_prev) begin
                    chk("post_rst_in_ready", int'(bus.in_ready), 1);
                    chk("post_rst_out_valid", int'(bus.out_valid), 0);
                    chk("post_rst_res", int'({bus.a1_out, bus.a2_out, bus.a3_out, bus.range_err}), 0);
                end
                if (post_hs) begin
                    chk("post_hs_out_valid", int'(bus.out_valid), 0);
                    chk("post_hs_in_ready", int'(bus.in_ready), 1);
                    post_hs = 1'b0;
                end
                if (busy) chk("busy_in_ready", int'(bus.in_ready), 0);
                if (bus.out_valid) begin
                    if (!busy || q.size() == 0) begin
                        chk("spurious_valid", 1, 0);
                    end else begin
                        exp_t e;
                        int   x;
                        e = q[0];
                        if (!prev_ov) chk("latency", cyc - e.acc, 9);
                        chk("a1", int'(bus.a1_out), e.e1);
                        chk("a2", int'(bus.a2_out), e.e2);
                        chk("a3", int'(bus.a3_out), e.e3);
                        chk("range_err", int'(bus.range_err), e.err);
                        if (e.v < 504) begin
                            x = (int'(bus.a1_out) * 280 + int'(bus.a2_out) * 441
                                 + int'(bus.a3_out) * 288) % 504;
                            chk("cmp10", sgn10(x), sgn10(e.v));
                        end
                        if (bus.out_ready) begin
                            void'(q.pop_front());
                            busy = 1'b0;
                            post_hs = 1'b1;
                        end
                    end
                end
                if (bus.in_valid && bus.in_ready) begin
                    if (busy) chk("accept_while_busy", 1, 0);
                    busy = 1'b1;
                    busy_cnt = 0;
                end
                if (busy) begin
                    busy_cnt++;
                    if (busy_cnt > 60) begin
                        chk("busy_timeout", busy_cnt, 60);
                        busy = 1'b0;
                        q.delete();
                    end
                end
                if (bus.in_valid && !bus.in_ready && !busy) begin
                    stall_cnt++;
                    if (stall_cnt == 40) chk("in_ready_timeout", stall_cnt, 0);
                end else begin
                    stall_cnt = 0;
                end
            end
            prev_ov = bus.out_valid;
            rst_prev = rst;
        end
    end

    task automatic issue(input int v);
        exp_t e;
        bus.bin_in   = 9'(v);
        bus.in_valid = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (bus.in_ready) break;
        end
        @(posedge clk);
        #1;
        e.v   = v;
        e.e1  = v % 9;
        e.e2  = v % 8;
        e.e3  = v % 7;
        e.err = (v >= 504) ? 1 : 0;
        e.acc = cyc;
        q.push_back(e);
        bus.in_valid = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // stimulus
    initial begin
        int dir[6];
        dir = '{10, 0, 503, 255, 504, 511};
        bus.bin_in   = 9'd7;
        bus.in_valid = 1'b1;          // in_valid during reset must not be accepted
        step(3);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        step(2);

        for (int i = 0; i < 6; i++) begin
            issue(dir[i]);
            step(12);
        end

        // backpressure plus an in_valid pulse during SHIFT
        rdy_mode = 2;
        man_rdy  = 1'b0;
        issue(10);
        step(2);
        bus.bin_in   = 9'd20;
        bus.in_valid = 1'b1;
        step(1);
        bus.in_valid = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.out_valid) break;
        end
        repeat (5) @(negedge clk);
        @(posedge clk); #1;
        man_rdy = 1'b1;
        step(1);
        man_rdy  = 1'b0;
        step(3);
        rdy_mode = 0;
        step(2);

        // reset on the 4th SHIFT cycle aborts the operand
        issue(100);
        step(3);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(15);
        issue(100);
        step(12);

        // exhaustive back-to-back sweep
        for (int v = 0; v < 512; v++) issue(v);
        step(12);

        // random operands with random downstream stalls and gaps
        rdy_mode = 1;
        for (int i = 0; i < 60; i++) begin
            issue(int'($urandom_range(0, 511)));
            step(int'($urandom_range(0, 3)));
        end
        rdy_mode = 0;
        step(30);
        done = 1'b1;
    end
endmodule

// File: doc/rns_forward_converter_9_8_7_seq.md
Name: rns_forward_converter_9_8_7_seq

Overview:
- Sequential binary-to-RNS forward converter for moduli set {9, 8, 7}; dynamic range M = 504.
- Sits directly upstream of the 9/8/7 RNS comparator and arithmetic stages: takes a 9-bit binary operand and produces residues in the same widths those stages consume (4/3/3 bits).
- Bit-serial, MSB-first residue accumulation; one operand in flight; valid/ready handshake on both sides.

Parameters:
- IN_WIDTH, 9, binary input width; also the number of SHIFT cycles.
- M1, 9, first modulus; residue on a1_out (4 bits).
- M2, 8, second modulus; residue on a2_out (3 bits).
- M3, 7, third modulus; residue on a3_out (3 bits).
- RANGE, 504, dynamic range; inputs >= RANGE set range_err.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- bin_in  input  IN_WIDTH  binary operand, sampled on input handshake.
- in_valid  input  1  bin_in valid.
- in_ready  output  1  converter can accept an operand.
- a1_out  output  4  bin mod M1.
- a2_out  output  3  bin mod M2.
- a3_out  output  3  bin mod M3.
- range_err  output  1  latched operand was >= RANGE.
- out_valid  output  1  residues valid.
- out_ready  input  1  downstream accepts residues.

Behaviour:
- Reset (rst high at an edge): state=IDLE; a1_out/a2_out/a3_out=0; range_err=0; out_valid=0; shift register and bit counter cleared. in_ready = (state==IDLE) && !rst, so it is 0 during reset and 1 on the first cycle after reset.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - Edge with in_valid=1: load bin_in into the shift register; clear the residue accumulators r1, r2, r3 to 0; set counter=IN_WIDTH; latch range_err = (bin_in >= RANGE); go to SHIFT.
  - in_valid=0: stay in IDLE.
- SHIFT:
  - in_ready=0; in_valid is ignored and the operand is not queued.
  - Each edge takes the MSB b of the shift register, shifts it left, and decrements counter.
  - For each modulus m: t = 2r + b; r' = (t >= m) ? t - m : t. Since t <= 2m-1, a single conditional subtract is sufficient.
  - The M2=8 path may instead use the low 3 bits of the operand directly; the result must be identical.
  - The edge on which counter goes 1->0 writes the final residues to a1/a2/a3_out and moves to DONE.
- DONE:
  - out_valid=1; outputs and range_err are held stable while out_ready=0.
  - Edge with out_ready=1: out_valid drops to 0 and state goes to IDLE. Outputs keep their last value; do not rely on them when out_valid=0.
- Latency: an accept at edge E0 gives out_valid=1 after edge E0+IN_WIDTH (9 cycles).
  - Minimum issue interval is IN_WIDTH+2 cycles (accept, 9 shifts, output handshake, return to IDLE).
  - There is no accept in the same cycle as the output handshake.
- range_err:
  - Operands 504..511 still produce their true residues mod 9/8/7.
  - These residues alias to (v - 504) in RNS, so downstream must discard the result when range_err=1.
- Reset mid-operation (SHIFT or DONE): aborts immediately; the pending result is dropped with no out_valid pulse; all outputs return to their reset values.
- Simultaneous in_valid and rst: rst wins; nothing is accepted.
- out_ready may be high in any state; it has effect only in DONE.

Test Plan:
- Reset, then bin_in=10 with in_valid held for 1 cycle -> after 9 cycles out_valid=1, (a1,a2,a3)=(1,2,3), range_err=0; in_ready=0 for the whole busy period.
- bin_in=0 -> (0,0,0); bin_in=503 -> (8,7,6), range_err=0; bin_in=255 -> (3,7,3).
- bin_in=504 -> (0,0,0), range_err=1; bin_in=511 -> (7,7,0), range_err=1.
- Backpressure: bin_in=10, hold out_ready=0 for 5 cycles after out_valid -> outputs (1,2,3) stable, in_ready=0. Then raise out_ready for 1 cycle -> out_valid=0 and in_ready=1 the next cycle. Pulsing in_valid with bin_in=20 during SHIFT has no effect on the result.
- Reset asserted for 1 cycle on the 4th SHIFT cycle of bin_in=100 -> out_valid never rises for that operand. A new bin_in=100 accepted afterwards -> (1,4,2) after 9 cycles.
- Exhaustive sweep 0..511, back-to-back, out_ready always 1 -> every result equals (v%9, v%8, v%7); range_err = (v >= 504); accept-to-valid latency is exactly 9 cycles. Feed results 0..503 into compare_9_8_7_const_10 -> (<, =, >) matches v versus 10.
